// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared S-box tables, default width and FSM state type for s_layer
package present_pkg;

    localparam int DEFAULT_SIZE = 64;

    // Packed so that element i of each table is the substitute for nibble value i.
    localparam logic [15:0][3:0] SBOX_FWD = 64'h21748FE3DA09B65C;
    localparam logic [15:0][3:0] SBOX_INV = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/present_sbox.sv
// rtl/present_sbox.sv - 4-bit S-box lookup; inverse table only with S_LAYER_INV_SBOX_EN
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dec,
    output logic [3:0] sub
);

`ifdef S_LAYER_INV_SBOX_EN
    assign sub = dec ? SBOX_INV[nib] : SBOX_FWD[nib];
`else
    logic unused_dec;
    assign unused_dec = dec;
    assign sub = SBOX_FWD[nib];
`endif

endmodule

// File: rtl/s_layer.sv
// rtl/s_layer.sv - round-key add plus NPC-nibble-per-cycle S-box layer; S_LAYER_INV_SBOX_EN enables decrypt
module s_layer
    import present_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int NPC  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_state,
    input  logic [SIZE-1:0] in_key,
    input  logic            dec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_state
);

    localparam int NGROUPS = SIZE / (4 * NPC);
    localparam int CW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NGROUPS - 1);

    state_t          fsm;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] st;
    logic            dec_q;
    logic [NPC-1:0][3:0] sb_in;
    logic [NPC-1:0][3:0] sb_out;

    always_comb begin
        sb_in = '0;
        for (int g = 0; g < NPC; g++) begin
            sb_in[g] = st[(int'(cnt) * NPC + g) * 4 +: 4];
        end
    end

    for (genvar g = 0; g < NPC; g++) begin : g_sbox
        present_sbox u_sbox (
            .nib (sb_in[g]),
            .dec (dec_q),
            .sub (sb_out[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            cnt       <= '0;
            st        <= '0;
            dec_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= in_state ^ in_key;
                        dec_q    <= dec;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        fsm      <= BUSY;
                    end
                end
                BUSY: begin
                    for (int g = 0; g < NPC; g++) begin
                        st[(int'(cnt) * NPC + g) * 4 +: 4] <= sb_out[g];
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    // in_ready is raised on the handoff edge, so IDLE accepts only from the next cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign out_state = st;

endmodule

// File: tb/tb_s_layer.sv
// tb/tb_s_layer.sv - directed self-checking bench for s_layer
module tb_s_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_state;
    logic [63:0] in_key;
    logic        dec;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_state;

    int checks = 0;
    int errors = 0;

    s_layer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .dec       (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [63:0] s, input logic [63:0] k, input logic d);
        in_state = s;
        in_key   = k;
        dec      = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0; dec = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 64'h0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_state=%h want 1 0 0", in_ready, out_valid, out_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero;
        int e;
        send(64'h0, 64'h0, 1'b0);
        wait_valid(e);
        checks++;
        if (e !== 4) begin errors++; $display("FAIL zero_latency: got %0d edges want 4", e); end
        checks++;
        if (out_state !== 64'hCCCCCCCCCCCCCCCC || in_ready !== 1'b0) begin
            errors++; $display("FAIL zero_value: got %h in_ready=%b want cccccccccccccccc 0", out_state, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL zero_handoff: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_key_ones;
        int e;
        send(64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        wait_valid(e);
        checks++;
        if (e !== 4 || out_state !== 64'h2222222222222222) begin
            errors++; $display("FAIL key_ones: edges=%0d got %h want 4 2222222222222222", e, out_state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nibble_order;
        int e;
        send(64'h0123456789ABCDEF, 64'h0, 1'b0);
        wait_valid(e);
        checks++;
        if (e !== 4 || out_state !== 64'hC56B90AD3EF84712) begin
            errors++; $display("FAIL nibble_order: edges=%0d got %h want 4 c56b90ad3ef84712", e, out_state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        int e;
        out_ready = 1'b0;
        send(64'h0123456789ABCDEF, 64'h0, 1'b0);
        wait_valid(e);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_state = 64'hFFFF0000FFFF0000 + 64'(i);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== 64'hC56B90AD3EF84712) begin
                errors++;
                $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b out_state=%h want 1 0 c56b90ad3ef84712",
                         i, out_valid, in_ready, out_state);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset;
        int e;
        send(64'h0123456789ABCDEF, 64'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 64'h0) begin
            errors++; $display("FAIL mid_reset: out_valid=%b in_ready=%b out_state=%h want 0 1 0", out_valid, in_ready, out_state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(64'h0, 64'h0, 1'b0);
        wait_valid(e);
        checks++;
        if (e !== 4 || out_state !== 64'hCCCCCCCCCCCCCCCC) begin
            errors++; $display("FAIL after_reset: edges=%0d got %h want 4 cccccccccccccccc", e, out_state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dec;
        int e;
`ifdef S_LAYER_INV_SBOX_EN
        send(64'hCCCCCCCCCCCCCCCC, 64'h0, 1'b1);
        dec = 1'b0;
        @(posedge clk);
        #1;
        dec = 1'b1;
        @(posedge clk);
        #1;
        dec = 1'b0;
        wait_valid(e);
        checks++;
        if (out_state !== 64'h0) begin
            errors++; $display("FAIL inverse: got %h want 0000000000000000", out_state);
        end
`else
        send(64'h0, 64'h0, 1'b1);
        wait_valid(e);
        checks++;
        if (out_state !== 64'hCCCCCCCCCCCCCCCC) begin
            errors++; $display("FAIL dec_ignored: got %h want cccccccccccccccc", out_state);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int e;
        send(64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        wait_valid(e);
        in_state = 64'h0123456789ABCDEF;
        in_key   = 64'h0;
        dec      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 64'h2222222222222222) begin
            errors++;
            $display("FAIL b2b_handoff: out_valid=%b in_ready=%b out_state=%h want 0 1 2222222222222222",
                     out_valid, in_ready, out_state);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(e);
        checks++;
        if (e !== 4 || out_state !== 64'hC56B90AD3EF84712) begin
            errors++; $display("FAIL b2b_second: edges=%0d got %h want 4 c56b90ad3ef84712", e, out_state);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_key_ones();
        test_nibble_order();
        test_backpressure();
        test_mid_reset();
        test_dec();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
